// File: rtl/snn_io_ctrl.sv
// Loads a packed UART image into the 1-bit input RAM, runs snn_core, returns the digit over UART.
// Byte -> 8 RAM writes on the next 8 cycles; a single pending byte is buffered during unpack, others drop and set overrun.
module snn_io_ctrl #(
    parameter int NUM_BYTES = 98,
    parameter int ADDR_W    = 10,
    parameter int ASCII_OUT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_d,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    input  logic              tx_rdy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [7:0]        led,
    output logic              busy,
    output logic              overrun
);

    localparam int BCW = $clog2(NUM_BYTES + 1);

    typedef enum logic [2:0] {
        LOAD   = 3'd0,
        UNPACK = 3'd1,
        START  = 3'd2,
        CORE   = 3'd3,
        SEND   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BCW-1:0]    byte_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift_dat;
    logic [7:0]        pend_dat;
    logic              pend_vld;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic              take_byte;
    logic              last_byte;
    logic [7:0]        digit_byte;

    assign take_byte  = (state == LOAD) && (pend_vld || rx_rdy);
    assign last_byte  = (byte_cnt == BCW'(NUM_BYTES - 1));
    // {byte_cnt, bit_cnt} is byte_cnt*8 + bit_cnt; the cast truncates or extends to the RAM width
    assign wr_addr    = ADDR_W'({byte_cnt, bit_cnt});
    assign digit_byte = (ASCII_OUT != 0) ? (8'h30 + {4'h0, core_digit}) : {4'h0, core_digit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (take_byte) state_nxt = UNPACK;
            UNPACK:  if (bit_cnt == 3'd7) state_nxt = last_byte ? START : LOAD;
            START:   state_nxt = CORE;
            CORE:    if (core_done) state_nxt = SEND;
            SEND:    if (tx_rdy) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        ram_we     = 1'b0;
        ram_addr   = last_addr;
        ram_d      = 1'b0;
        core_start = 1'b0;
        busy       = (state != LOAD);
        case (state)
            UNPACK: begin
                ram_we   = 1'b1;
                ram_addr = wr_addr;
                ram_d    = shift_dat[bit_cnt];
            end
            START:   core_start = 1'b1;
            CORE:    ram_addr = core_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            shift_dat <= '0;
            pend_dat  <= '0;
            pend_vld  <= 1'b0;
            last_addr <= '0;
            overrun   <= 1'b0;
            led       <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                LOAD: begin
                    // a buffered byte goes first; a coincident new byte takes its slot
                    if (pend_vld) begin
                        shift_dat <= pend_dat;
                        pend_vld  <= rx_rdy;
                        if (rx_rdy) pend_dat <= rx_data;
                    end else if (rx_rdy) begin
                        shift_dat <= rx_data;
                    end
                end
                UNPACK: begin
                    last_addr <= wr_addr;
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) byte_cnt <= byte_cnt + BCW'(1);
                    if (rx_rdy) begin
                        if (pend_vld) begin
                            overrun <= 1'b1;
                        end else begin
                            pend_vld <= 1'b1;
                            pend_dat <= rx_data;
                        end
                    end
                end
                START: begin
                    byte_cnt <= '0;
                    if (rx_rdy) overrun <= 1'b1;
                end
                CORE: begin
                    if (rx_rdy) overrun <= 1'b1;
                    if (core_done) begin
                        led     <= {4'h0, core_digit};
                        tx_data <= digit_byte;
                    end
                end
                SEND: begin
                    if (rx_rdy) overrun <= 1'b1;
                    if (tx_rdy) tx_start <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_io_ctrl.sv
// Directed bench for snn_io_ctrl: image load, core handoff, pend/overrun, reset abort, tx hold-off.
module tb_snn_io_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_d;
    logic [9:0] core_addr = 10'd0;
    logic       core_start;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = 4'h0;
    logic       tx_rdy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] led;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int   wa_q[$];
    logic wd_q[$];
    int   n_start = 0;
    int   n_tx = 0;
    int   start_cyc = 0;
    int   tx_cyc = 0;
    int   done_cyc = 0;
    int   rx_cyc = 0;

    snn_io_ctrl #(.NUM_BYTES(98), .ADDR_W(10), .ASCII_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .core_addr(core_addr),
        .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
        .tx_rdy(tx_rdy), .tx_start(tx_start), .tx_data(tx_data), .led(led),
        .busy(busy), .overrun(overrun)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we) begin
            wa_q.push_back(int'(ram_addr));
            wd_q.push_back(ram_d);
        end
        if (rx_rdy) rx_cyc = cyc;
        if (core_done) done_cyc = cyc;
        if (core_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (tx_start) begin
            n_tx++;
            tx_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        @(posedge clk); #1;
        rx_rdy  = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic pulse_done(input logic [3:0] d);
        @(posedge clk); #1;
        core_digit = d;
        core_done  = 1'b1;
        @(posedge clk); #1;
        core_done  = 1'b0;
        core_digit = 4'h0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ram_we, ram_d, core_start, tx_start, busy, overrun} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {ram_we, ram_d, core_start, tx_start, busy, overrun});
        end
        checks++;
        if (ram_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", ram_addr); end
        checks++;
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++;
        if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Full image of 8'hA5 bytes spaced 20 cycles
    task automatic test_image;
        int base = wa_q.size();
        int s0 = n_start;
        int bad = 0;
        int w = 0;
        logic [7:0] pat = 8'hA5;
        for (int k = 0; k < 98; k++) send_byte(8'hA5, 20);
        while (n_start == s0 && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (wa_q.size() - base !== 784) begin errors++; $display("FAIL image_wr_count: got %0d expected 784", wa_q.size() - base); end
        for (int i = 0; i < 784 && base + i < wa_q.size(); i++)
            if (wa_q[base + i] !== i || wd_q[base + i] !== pat[i % 8]) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL image_wr_data: got %0d bad writes expected 0", bad); end
        checks++;
        if (n_start - s0 !== 1) begin errors++; $display("FAIL image_start_count: got %0d expected 1", n_start - s0); end
        checks++;
        if (start_cyc - rx_cyc !== 9) begin errors++; $display("FAIL image_start_latency: got %0d expected 9", start_cyc - rx_cyc); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || core_start !== 1'b0) begin errors++; $display("FAIL image_core_state: busy=%b start=%b expected 1 0", busy, core_start); end
    endtask

    task automatic test_core;
        int bad = 0;
        int t0 = n_tx;
        int w = 0;
        for (int a = 0; a < 784; a++) begin
            @(posedge clk); #1;
            core_addr = 10'(a);
            @(negedge clk);
            if (ram_addr !== 10'(a) || ram_we !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL core_addr_pass: got %0d bad cycles expected 0", bad); end
        core_addr = 10'd5;
        tx_rdy = 1'b1;
        pulse_done(4'd7);
        while (n_tx == t0 && w < 10) begin @(negedge clk); w++; end
        checks++;
        if (led !== 8'h07) begin errors++; $display("FAIL core_led: got %h expected 07", led); end
        checks++;
        if (tx_data !== 8'h37) begin errors++; $display("FAIL core_tx_data: got %h expected 37", tx_data); end
        checks++;
        if (tx_cyc - done_cyc !== 2) begin errors++; $display("FAIL core_tx_latency: got %0d expected 2", tx_cyc - done_cyc); end
        repeat (5) @(negedge clk);
        checks++;
        if (n_tx - t0 !== 1) begin errors++; $display("FAIL core_tx_count: got %0d expected 1", n_tx - t0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL core_back_to_load: busy=%b expected 0", busy); end
        checks++;
        if (ram_addr !== 10'd783 || ram_we !== 1'b0) begin errors++; $display("FAIL core_addr_hold: got %0d we=%b expected 783 0", ram_addr, ram_we); end
        core_addr = 10'd0;
    endtask

    // Bytes 2 cycles apart: second buffered, third dropped
    task automatic test_pend;
        int base;
        int bad = 0;
        int t0 = n_tx;
        logic [7:0] bv;
        pulse_done(4'd9);
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 8'h07 || n_tx !== t0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: led=%h tx=%0d busy=%b expected 07 %0d 0", led, n_tx, busy, t0);
        end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL pend_overrun_pre: got %b expected 0", overrun); end
        base = wa_q.size();
        send_byte(8'h01, 2);
        send_byte(8'h02, 2);
        send_byte(8'h03, 2);
        repeat (30) @(negedge clk);
        checks++;
        if (wa_q.size() - base !== 16) begin errors++; $display("FAIL pend_wr_count: got %0d expected 16", wa_q.size() - base); end
        for (int i = 0; i < 16 && base + i < wa_q.size(); i++) begin
            bv = 8'(i / 8 + 1);
            if (wa_q[base + i] !== i || wd_q[base + i] !== bv[i % 8]) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL pend_wr_data: got %0d bad writes expected 0", bad); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL pend_overrun: got %b expected 1", overrun); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL pend_idle: busy=%b expected 0", busy); end
    endtask

    // 48 more bytes make 50 in this image, then reset aborts it
    task automatic test_reset_mid;
        int base;
        int s0;
        int bad = 0;
        int w = 0;
        logic [7:0] bv;
        for (int k = 0; k < 48; k++) send_byte(8'hFF, 12);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_we, ram_d, core_start, tx_start, busy, overrun} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: got %b expected 000000", {ram_we, ram_d, core_start, tx_start, busy, overrun});
        end
        checks++;
        if (led !== 8'h00 || tx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_regs: led=%h tx=%h expected 00 00", led, tx_data); end
        checks++;
        if (ram_addr !== 10'd0) begin errors++; $display("FAIL rst_mid_addr: got %0d expected 0", ram_addr); end
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        base = wa_q.size();
        s0 = n_start;
        for (int k = 0; k < 98; k++) send_byte(8'(k * 7 + 8'h5A), 10);
        while (n_start == s0 && w < 50) begin @(negedge clk); w++; end
        checks++;
        if (wa_q.size() - base !== 784) begin errors++; $display("FAIL rst_img_wr_count: got %0d expected 784", wa_q.size() - base); end
        for (int i = 0; i < 784 && base + i < wa_q.size(); i++) begin
            bv = 8'((i / 8) * 7 + 8'h5A);
            if (wa_q[base + i] !== i || wd_q[base + i] !== bv[i % 8]) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rst_img_wr_data: got %0d bad writes expected 0", bad); end
        checks++;
        if (n_start - s0 !== 1) begin errors++; $display("FAIL rst_img_start_count: got %0d expected 1", n_start - s0); end
        checks++;
        if (start_cyc - rx_cyc !== 9) begin errors++; $display("FAIL rst_img_start_latency: got %0d expected 9", start_cyc - rx_cyc); end
    endtask

    task automatic test_core_overrun;
        int base = wa_q.size();
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL core_ovr_pre: ovr=%b busy=%b expected 0 1", overrun, busy); end
        send_byte(8'hFF, 4);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL core_ovr_flag: got %b expected 1", overrun); end
        checks++;
        if (wa_q.size() !== base) begin errors++; $display("FAIL core_ovr_no_write: got %0d writes expected 0", wa_q.size() - base); end
    endtask

    task automatic test_tx_hold;
        int t0 = n_tx;
        int w = 0;
        tx_rdy = 1'b0;
        pulse_done(4'd3);
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++;
        if (n_tx !== t0 || busy !== 1'b1) begin errors++; $display("FAIL hold_no_tx: tx=%0d busy=%b expected %0d 1", n_tx, busy, t0); end
        checks++;
        if (tx_data !== 8'h33 || led !== 8'h03) begin errors++; $display("FAIL hold_result: tx=%h led=%h expected 33 03", tx_data, led); end
        @(posedge clk); #1;
        tx_rdy = 1'b1;
        while (n_tx == t0 && w < 10) begin @(negedge clk); w++; end
        repeat (5) @(negedge clk);
        checks++;
        if (n_tx - t0 !== 1) begin errors++; $display("FAIL hold_tx_count: got %0d expected 1", n_tx - t0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL hold_back_to_load: busy=%b expected 0", busy); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL hold_overrun_sticky: got %b expected 1", overrun); end
    endtask

    initial begin
        test_reset();
        test_image();
        test_core();
        test_pend();
        test_reset_mid();
        test_core_overrun();
        test_tx_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
